key_led_ctrl: RTL and testbench

//  Parametrised successor to the single key-to-LED path. Handles N_CH push-button/LED channels.

---
 rtl/key_led_ctrl_pkg.sv | 16 +
 rtl/key_led_ctrl_debounce.sv | 64 ++++++
 rtl/key_led_ctrl.sv | 101 ++++++++++
 tb/tb_key_led_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_ctrl_pkg.sv
// Shared definitions for the key/LED controller: per-channel mode encoding
// and a helper that tells whether a mode keeps per-channel state.
package key_led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FOLLOW = 2'd0;
  localparam mode_t MODE_TOGGLE = 2'd1;
  localparam mode_t MODE_BLINK  = 2'd2;
  localparam mode_t MODE_RSVD   = 2'd3;

  function automatic logic mode_uses_st(input mode_t m);
    return (m == MODE_TOGGLE) || (m == MODE_BLINK);
  endfunction

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// One key channel: 2-FF synchroniser, stability counter and a registered
// one-cycle press pulse generated after the debounced level falls.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_db,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_db;
  logic             r_db_prev;
  logic             r_press;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept the synced level only after it has differed for DEBOUNCE_CYC edges.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt    <= '0;
      r_key_db <= 1'b1;
    end else if (r_sync2 == r_key_db) begin
      r_cnt    <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_key_db <= r_sync2;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_db_prev <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_db_prev <= r_key_db;
      r_press   <= r_db_prev & ~r_key_db;
    end
  end

  assign key_db = r_key_db;
  assign press  = r_press;

endmodule

// File: rtl/key_led_ctrl.sv
// N_CH debounced push-button channels, each driving an LED in FOLLOW,
// TOGGLE or BLINK mode; blinking channels share one phase generator.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int BLINK_CYC    = 25000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_CH-1:0]     key,
  input  logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     key_db,
  output logic [N_CH-1:0]     press,
  output logic [N_CH-1:0]     led
);

  localparam int                BLK_W    = $clog2(BLINK_CYC);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  logic [N_CH-1:0]   w_key_db;
  logic [N_CH-1:0]   w_press;
  logic [N_CH-1:0]   w_st_nxt;
  logic [N_CH-1:0]   w_led_nxt;

  logic [BLK_W-1:0]  r_blink_cnt;
  logic              r_phase;
  logic [2*N_CH-1:0] r_mode;
  logic [N_CH-1:0]   r_st;
  logic [N_CH-1:0]   r_led;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_raw (key[gi]),
        .key_db  (w_key_db[gi]),
        .press   (w_press[gi])
      );
    end
  endgenerate

  // Shared blink timebase; the phase flips on every wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLK_ONE;
    end
  end

  // A mode change clears st and swallows a coincident press.
  always_comb begin
    w_st_nxt  = '0;
    w_led_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (mode[2*i +: 2] != r_mode[2*i +: 2]) begin
        w_st_nxt[i] = 1'b0;
      end else if (mode_uses_st(mode_t'(r_mode[2*i +: 2]))) begin
        w_st_nxt[i] = r_st[i] ^ w_press[i];
      end else begin
        w_st_nxt[i] = 1'b0;
      end

      case (mode_t'(r_mode[2*i +: 2]))
        MODE_FOLLOW: w_led_nxt[i] = ~w_key_db[i];
        MODE_TOGGLE: w_led_nxt[i] = r_st[i];
        MODE_BLINK:  w_led_nxt[i] = r_st[i] & r_phase;
        MODE_RSVD:   w_led_nxt[i] = 1'b0;
        default:     w_led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_mode <= '0;
      r_st   <= '0;
      r_led  <= '0;
    end else begin
      r_mode <= mode;
      r_st   <= w_st_nxt;
      r_led  <= w_led_nxt;
    end
  end

  assign key_db = w_key_db;
  assign press  = w_press;
  assign led    = r_led;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Self-checking bench for key_led_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_key_led_ctrl;

  localparam int N_CH = 4;
  localparam int DEB  = 4;
  localparam int BLK  = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [N_CH-1:0] key     = 4'hF;
  logic [7:0]      mode    = 8'h00;
  logic [N_CH-1:0] key_db;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] led;

  key_led_ctrl #(
    .N_CH         (N_CH),
    .DEBOUNCE_CYC (DEB),
    .BLINK_CYC    (BLK)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (key),
    .mode    (mode),
    .key_db  (key_db),
    .press   (press),
    .led     (led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge sys_clk);
  endtask

  // Reference model: synced value is the raw key from two edges back, a level
  // is accepted after DEB consecutive differing samples, blink phase is derived
  // from the number of edges since reset.
  bit              m_valid = 1'b0;
  logic [3:0]      m_db, m_press, m_led, m_st, m_fell;
  logic [7:0]      m_mode;
  logic [3:0]      m_pipe[$];
  int              m_run[4];
  int unsigned     m_ncyc;

  always @(posedge sys_clk) begin : model
    logic [3:0] syncd;
    logic [3:0] led_n;
    logic [3:0] press_n;
    logic [1:0] md_old;
    logic [1:0] md_new;
    bit         ph;
    if (sys_rst) begin
      m_valid = 1'b1;
      m_db    = 4'hF;
      m_press = 4'h0;
      m_led   = 4'h0;
      m_st    = 4'h0;
      m_fell  = 4'h0;
      m_mode  = 8'h00;
      m_pipe  = '{4'hF, 4'hF};
      m_ncyc  = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      ph    = ((m_ncyc / BLK) % 2) == 1;
      syncd = m_pipe.pop_front();
      m_pipe.push_back(key);
      for (int i = 0; i < 4; i++) begin
        md_old = m_mode[2*i +: 2];
        md_new = mode[2*i +: 2];
        case (md_old)
          2'd0:    led_n[i] = ~m_db[i];
          2'd1:    led_n[i] = m_st[i];
          2'd2:    led_n[i] = m_st[i] & ph;
          default: led_n[i] = 1'b0;
        endcase
        if (md_new != md_old)                 m_st[i] = 1'b0;
        else if (md_old == 2'd1 || md_old == 2'd2) m_st[i] = m_st[i] ^ m_press[i];
        else                                  m_st[i] = 1'b0;
      end
      press_n = m_fell;
      m_fell  = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (syncd[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i]  = syncd[i];
            m_run[i] = 0;
            if (!syncd[i]) m_fell[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_mode  = mode;
      m_press = press_n;
      m_led   = led_n;
      m_ncyc++;
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("model_key_db", key_db, m_db);
      check("model_press",  press,  m_press);
      check("model_led",    led,    m_led);
    end
  end

  int n, pulses, h;
  logic seen_db, seen_press, seen_led, led_after_first;

  initial begin
    sys_rst = 1'b1;
    tick(3);
    check("rst_key_db", key_db, 4'hF);
    check("rst_led",    led,    4'h0);
    check("rst_press",  press,  4'h0);
    sys_rst = 1'b0;
    tick(4);

    // Bounce shorter than the debounce window
    key[0] = 1'b0;
    tick(3);
    key[0] = 1'b1;
    seen_db = 1'b0; seen_press = 1'b0; seen_led = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_db    = seen_db    | ~key_db[0];
      seen_press = seen_press | press[0];
      seen_led   = seen_led   | led[0];
    end
    check("bounce_db",    seen_db,    1'b0);
    check("bounce_press", seen_press, 1'b0);
    check("bounce_led",   seen_led,   1'b0);

    // FOLLOW latency on press and release
    key[0] = 1'b0;
    n = 0;
    while (key_db[0] !== 1'b0 && n < 20) begin tick(); n++; end
    check("follow_fall_lat", n, 6);
    check("follow_press_early", press[0], 1'b0);
    tick();
    check("follow_press", press[0], 1'b1);
    check("follow_led_on", led[0], 1'b1);
    tick();
    check("follow_press_one", press[0], 1'b0);
    key[0] = 1'b1;
    n = 0;
    while (key_db[0] !== 1'b1 && n < 20) begin tick(); n++; end
    check("follow_rise_lat", n, 6);
    tick();
    check("follow_led_off", led[0], 1'b0);
    check("follow_no_rel_press", press[0], 1'b0);
    tick(4);

    // TOGGLE on ch1
    mode = 8'b00_00_01_00;
    tick(2);
    pulses = 0;
    led_after_first = 1'b0;
    for (int p = 0; p < 2; p++) begin
      key[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(); if (press[1] === 1'b1) pulses++; end
      key[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); if (press[1] === 1'b1) pulses++; end
      if (p == 0) led_after_first = led[1];
    end
    check("toggle_pulses", pulses, 2);
    check("toggle_led_first", led_after_first, 1'b1);
    check("toggle_led_second", led[1], 1'b0);

    // BLINK on ch2
    mode = 8'b00_10_00_00;
    tick(2);
    key[2] = 1'b0; tick(10); key[2] = 1'b1; tick(10);
    n = 0;
    while (led[2] !== 1'b0 && n < 20) begin tick(); n++; end
    n = 0;
    while (led[2] !== 1'b1 && n < 20) begin tick(); n++; end
    check("blink_rise_seen", led[2], 1'b1);
    h = 0;
    while (led[2] === 1'b1 && h < 40) begin tick(); h++; end
    check("blink_high_len", h, 8);
    h = 0;
    while (led[2] === 1'b0 && h < 40) begin tick(); h++; end
    check("blink_low_len", h, 8);
    key[2] = 1'b0; tick(10); key[2] = 1'b1; tick(10);
    seen_led = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); seen_led = seen_led | led[2]; end
    check("blink_off", seen_led, 1'b0);

    // Concurrent presses in all four modes, then ch1 to FOLLOW
    mode = 8'b11_10_01_00;
    tick(2);
    key = 4'h0;
    n = 0;
    while (press === 4'h0 && n < 20) begin tick(); n++; end
    check("conc_press", press, 4'hF);
    tick(3);
    check("conc_led", led & 4'b1011, 4'b0011);
    mode = 8'b11_10_00_00;
    tick(2);
    check("modechg_follow_led", led[1], 1'b1);
    key[1] = 1'b1;
    tick(10);
    check("modechg_follow_rel", led[1], 1'b0);
    key = 4'hF;
    tick(12);

    // Reset in the middle of operation
    mode = 8'b00_00_01_00;
    tick(2);
    key[1] = 1'b0; tick(10); key[1] = 1'b1; tick(10);
    check("midrst_led_pre", led[1], 1'b1);
    key[0] = 1'b0;
    tick(4);
    sys_rst = 1'b1;
    tick();
    check("midrst_led", led, 4'h0);
    check("midrst_key_db", key_db, 4'hF);
    check("midrst_press", press, 4'h0);
    sys_rst = 1'b0;
    n = 0;
    while (key_db[0] !== 1'b0 && n < 20) begin tick(); n++; end
    check("midrst_lat", n, 6);
    key = 4'hF;
    tick(12);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 5) == 0) key[ch] = ~key[ch];
        if ($urandom_range(0, 39) == 0) mode[2*ch +: 2] = 2'($urandom_range(0, 3));
      end
      sys_rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    sys_rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
